// File: rtl/pattern_gen_pkg.sv
// pattern_gen_pkg: shared mode and state encodings for the pattern generator
package pattern_gen_pkg;
  localparam logic [1:0] MODE_INC   = 2'd0;
  localparam logic [1:0] MODE_DEC   = 2'd1;
  localparam logic [1:0] MODE_CONST = 2'd2;
  localparam logic [1:0] MODE_LFSR  = 2'd3;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;
endpackage

// File: rtl/pattern_gen_next.sv
// pattern_gen_next: next-word arithmetic (inc/dec/const/Galois LFSR) modulo 2^WIDTH
module pattern_gen_next
  import pattern_gen_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY  = 8'hB8
) (
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] step,
  output logic [WIDTH-1:0] nxt
);
  always_comb
    nxt = mode == MODE_INC   ? d + step :
          mode == MODE_DEC   ? d - step :
          mode == MODE_CONST ? d :
          d[0]               ? (d >> 1) ^ POLY : d >> 1;
endmodule

// File: rtl/pattern_gen.sv
// pattern_gen: multi-mode burst/continuous test-pattern source with valid/ready output
module pattern_gen
  import pattern_gen_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter int               LEN_W = 16,
  parameter logic [WIDTH-1:0] POLY  = 8'hB8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] seed,
  input  logic [WIDTH-1:0] step,
  input  logic [LEN_W-1:0] burst_len,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             last,
  output logic             busy,
  output logic             done
);
  state_t           state;
  logic [1:0]       cfg_mode;
  logic [WIDTH-1:0] cfg_step, nxt;
  logic [LEN_W-1:0] cfg_len, cnt, cnt_n;
  logic             xfer;
  assign xfer  = out_valid && out_ready;
  assign cnt_n = cnt + LEN_W'(1);
  pattern_gen_next #(.WIDTH(WIDTH), .POLY(POLY)) u_next (
    .mode (cfg_mode),
    .d    (data_out),
    .step (cfg_step),
    .nxt  (nxt)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state     <= ST_IDLE;
      cfg_mode  <= MODE_INC;
      cfg_step  <= '0;
      cfg_len   <= '0;
      cnt       <= '0;
      data_out  <= '0;
      out_valid <= 1'b0;
      last      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else
      case (state)
        ST_IDLE:
          if (start) begin
            state     <= ST_RUN;
            cfg_mode  <= mode;
            cfg_step  <= step;
            cfg_len   <= burst_len;
            cnt       <= '0;
            data_out  <= (mode == MODE_LFSR && seed == '0) ? WIDTH'(1) : seed;
            out_valid <= 1'b1;
            last      <= burst_len == LEN_W'(1);
            busy      <= 1'b1;
          end
        ST_RUN: begin
          if (xfer) begin
            cnt      <= cnt_n;
            data_out <= nxt;
            last     <= cfg_len != '0 && cnt_n == cfg_len - LEN_W'(1);
          end
          if ((xfer && last) || stop) begin
            state     <= ST_DONE;
            out_valid <= 1'b0;
            last      <= 1'b0;
            done      <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
endmodule

// File: doc/pattern_gen.md
Name: pattern_gen

Overview:
Parametrised multi-mode test-pattern generator; next generation of the team's 8-bit self-incrementing data source.
Emits a burst or continuous stream of WIDTH-bit words under a valid/ready handshake.
Supported patterns: increment, decrement, constant and LFSR, with programmable seed, step and burst length.
Sits at the head of the simulation datapath, feeding downstream sinks and checkers.

Parameters:
WIDTH, 8, data word width in bits (>=2)
LEN_W, 16, width of burst length and beat counter
POLY, 8'hB8, Galois LFSR feedback mask (WIDTH bits), used in LFSR mode

Ports:
clk  input  1  single clock, all logic on posedge
rst  input  1  asynchronous reset, active-low (rst==0 resets)
start  input  1  one-cycle request to begin a burst; sampled only in IDLE
stop  input  1  abort the current burst; sampled only in RUN
mode  input  2  0=INC, 1=DEC, 2=CONST, 3=LFSR; latched on accepted start
seed  input  WIDTH  first word of the burst; latched on start
step  input  WIDTH  increment/decrement amount; latched on start
burst_len  input  LEN_W  beats per burst; 0 = continuous; latched on start
data_out  output  WIDTH  current word
out_valid  output  1  data_out is valid
out_ready  input  1  downstream accepts data_out this cycle
last  output  1  data_out is final beat of burst (qualified by out_valid)
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse when burst completes or is aborted

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; data_out=0, out_valid=0, last=0, busy=0, done=0; counter and latched config cleared.
- FSM states:
  - IDLE: start=1 -> RUN. Latches mode/seed/step/burst_len; data_out<=seed; out_valid<=1 next cycle, so first word is presented 1 cycle after start. start while busy is ignored.
  - RUN: a transfer is out_valid&&out_ready. On transfer: beat count++; data_out<=next(data_out).
    - On the transfer with last=1: out_valid<=0, -> DONE.
    - Without a transfer, data_out, out_valid and last hold stable (no change while stalled).
  - DONE: done=1 for exactly this cycle, busy=1, out_valid=0 -> IDLE.
- last=1 when burst_len!=0 and count==burst_len-1. burst_len==1 -> first beat carries last. burst_len==0 -> last never asserted; counter free-wraps and is ignored.
- stop in RUN with no transfer: out_valid<=0, -> DONE (done pulse), no further beats.
- stop in the same cycle as a transfer: that beat counts as delivered, then -> DONE.
- stop in IDLE/DONE: ignored.
- next() rules, all modulo 2^WIDTH:
  - INC: d+step; wraps silently.
  - DEC: d-step; wraps silently.
  - CONST: d unchanged.
  - LFSR: if d[0], (d>>1)^POLY; else d>>1.
  - LFSR seed of 0 is replaced by 1 at latch time, avoiding lock-up.
- Reset asserted mid-burst: all outputs return to reset values immediately; no done pulse.
- Inputs mode/seed/step/burst_len changing during RUN have no effect.

Decomposition:
- Shared package pattern_gen_pkg holds:
  - mode encodings MODE_INC=0, MODE_DEC=1, MODE_CONST=2, MODE_LFSR=3;
  - state encodings ST_IDLE, ST_RUN, ST_DONE.
- One combinational sub-module, pattern_gen_next (mode, d, step -> next d, parametrised by WIDTH and POLY). Keeps the FSM and the pattern arithmetic separately testable.

Test Plan:
- INC wrap: WIDTH=8, mode=0, seed=0xFE, step=1, burst_len=4, ready=1 -> beats FE,FF,00,01; last only on 01; done pulses 1 cycle after the 01 transfer.
- DEC + backpressure: mode=1, seed=0x05, step=2, burst_len=3, ready low 3 cycles after first beat -> 05 held stable and valid during stall, then 03,01; last on 01.
- LFSR: mode=3, seed=0x01, POLY=0xB8, burst_len=5 -> 01,B8,5C,2E,17. With seed=0x00 the first word is 01.
- CONST continuous: mode=2, seed=0xA5, burst_len=0, 300 beats -> all A5, last never high. stop asserted with ready=0 -> valid drops next cycle, done pulses once.
- stop coincident with transfer: INC seed=0x10 step=1, stop on the 3rd transfer -> exactly 10,11,12 delivered, done pulse, busy low afterwards. start during RUN is ignored.
- Async reset mid-burst: rst low between clock edges while out_valid=1 -> data_out=0, out_valid=0, busy=0 immediately. After rst high, a new start begins cleanly from the new seed.
